// File: rtl/tpu_seq_pkg.sv
// rtl/tpu_seq_pkg.sv - shared state encoding and default sizing for the tile sequencer
package tpu_seq_pkg;

    localparam int SEQ_N_DEF        = 3;
    localparam int SEQ_PIPE_LAT_DEF = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/seq_valid_delay.sv
// rtl/seq_valid_delay.sv - 1-bit valid delay line with flush, feeding the alignment stage
module seq_valid_delay #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic valid_in,
    output logic valid_out,
    output logic empty
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (flush) begin
            sr <= '0;
        end else begin
            sr <= (sr << 1) | DEPTH'(valid_in);
        end
    end

    assign valid_out = sr[DEPTH-1];
    // High while the output stage holds the last pending valid, so the line is clear after this edge
    assign empty     = ~valid_in & ~|(sr << 1);

endmodule

// File: rtl/systolic_tile_sequencer.sv
// rtl/systolic_tile_sequencer.sv - per-tile weight load / activation stream / drain sequencer (SEQ_PERF_CNT_EN adds busy-cycle counter)
module systolic_tile_sequencer
    import tpu_seq_pkg::*;
#(
    parameter int N         = SEQ_N_DEF,
    parameter int ADDR_W    = 8,
    parameter int ROW_CNT_W = 8,
    parameter int PIPE_LAT  = SEQ_PIPE_LAT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ROW_CNT_W-1:0]   num_rows,
    input  logic [ADDR_W-1:0]      wt_base,
    input  logic [ADDR_W-1:0]      act_base,
    output logic                   busy,
    output logic                   done,
    output logic                   wt_rd_en,
    output logic [ADDR_W-1:0]      wt_rd_addr,
    output logic                   wt_load_en,
    output logic [$clog2(N)-1:0]   wt_row_sel,
    output logic                   act_rd_en,
    output logic [ADDR_W-1:0]      act_rd_addr,
    output logic                   sa_act_valid,
    output logic                   acc_valid_out,
    output logic [31:0]            perf_cycles
);

    localparam int SEL_W = $clog2(N);

    seq_state_t             state;
    logic [ROW_CNT_W-1:0]   cnt;
    logic [ROW_CNT_W-1:0]   rows_q;
    logic [ADDR_W-1:0]      wt_base_q;
    logic [ADDR_W-1:0]      act_base_q;
    logic                   drain_empty;

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign wt_rd_en    = (state == LOAD_W);
    assign act_rd_en   = (state == STREAM);
    assign wt_rd_addr  = wt_rd_en  ? wt_base_q  + ADDR_W'(cnt) : '0;
    assign act_rd_addr = act_rd_en ? act_base_q + ADDR_W'(cnt) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            rows_q       <= '0;
            wt_base_q    <= '0;
            act_base_q   <= '0;
            wt_load_en   <= 1'b0;
            wt_row_sel   <= '0;
            sa_act_valid <= 1'b0;
        end else begin
            wt_load_en   <= wt_rd_en & ~abort;
            wt_row_sel   <= (wt_rd_en & ~abort) ? SEL_W'(cnt) : '0;
            sa_act_valid <= act_rd_en & ~abort;
            if (abort) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            rows_q     <= num_rows;
                            wt_base_q  <= wt_base;
                            act_base_q <= act_base;
                            cnt        <= '0;
                            state      <= LOAD_W;
                        end
                    end
                    LOAD_W: begin
                        if (cnt == ROW_CNT_W'(N - 1)) begin
                            cnt   <= '0;
                            state <= (rows_q == '0) ? DRAIN : STREAM;
                        end else begin
                            cnt <= cnt + ROW_CNT_W'(1);
                        end
                    end
                    STREAM: begin
                        if (cnt == rows_q - ROW_CNT_W'(1)) begin
                            cnt   <= '0;
                            state <= DRAIN;
                        end else begin
                            cnt <= cnt + ROW_CNT_W'(1);
                        end
                    end
                    DRAIN: begin
                        if (drain_empty) begin
                            state <= DONE;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    seq_valid_delay #(
        .DEPTH (PIPE_LAT)
    ) u_valid_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .valid_in  (sa_act_valid),
        .valid_out (acc_valid_out),
        .empty     (drain_empty)
    );

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (busy && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule
